median_window_fetch: RTL and testbench

- Upstream stage of the 3x3 median filter datapath.
- On a start request with a centre pixel coordinate, fetches the 3x3 neighbourhood from the single-channel image SRAM over a synchronous read port.
- Pixels outside the image are zero-padded.
- Presents the nine pixels in row-major order as a registered window with a one-cycle valid pulse, directly feeding the median finder's nine data inputs.

---
 rtl/median_window_fetch.sv | 135 +++++++++++++
 tb/tb_median_window_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/median_window_fetch.sv
// 3x3 window fetch for the median filter: reads the neighbourhood of a centre
// pixel from a synchronous-read SRAM, zero-pads off-image taps, emits one window.
module median_window_fetch #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int COORD_W = 3,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [COORD_W-1:0] i_row,
  input  logic [COORD_W-1:0] i_col,
  output logic               o_mem_ren,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic [DATA_W-1:0]  i_mem_rdata,
  output logic               o_busy,
  output logic               o_valid,
  output logic [DATA_W-1:0]  o_data0,
  output logic [DATA_W-1:0]  o_data1,
  output logic [DATA_W-1:0]  o_data2,
  output logic [DATA_W-1:0]  o_data3,
  output logic [DATA_W-1:0]  o_data4,
  output logic [DATA_W-1:0]  o_data5,
  output logic [DATA_W-1:0]  o_data6,
  output logic [DATA_W-1:0]  o_data7,
  output logic [DATA_W-1:0]  o_data8
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  // Two bits of headroom keep row -1 and row IMG_H distinct from in-range rows.
  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] ONE_S = SW'(1);
  localparam logic signed [SW-1:0] W_S   = SW'(IMG_W);
  localparam logic signed [SW-1:0] H_S   = SW'(IMG_H);
  localparam logic [COORD_W:0]     ROW_LIM = (COORD_W+1)'(IMG_H);
  localparam logic [COORD_W:0]     COL_LIM = (COORD_W+1)'(IMG_W);

  state_t                   state;
  logic [3:0]               slot;
  logic [COORD_W-1:0]       c_row, c_col;
  logic                     pend, pend_rd;
  logic [3:0]               pend_slot;
  logic [8:0][DATA_W-1:0]   win;
  logic                     start_ok;
  logic [ADDR_W:0]          first_rd, next_rd;

  // Returns {in_bounds, address} for tap k of the window centred on (r, c).
  function automatic logic [ADDR_W:0] slot_rd(input logic [COORD_W-1:0] r,
                                               input logic [COORD_W-1:0] c,
                                               input logic [3:0]         k);
    logic [3:0]             dr, dc;
    logic signed [SW-1:0]   pr, pc;
    logic                   inb;
    dr  = k / 4'd3;
    dc  = k % 4'd3;
    pr  = $signed({2'b00, r}) - ONE_S + $signed({{(SW-4){1'b0}}, dr});
    pc  = $signed({2'b00, c}) - ONE_S + $signed({{(SW-4){1'b0}}, dc});
    inb = !pr[SW-1] && (pr < H_S) && !pc[SW-1] && (pc < W_S);
    return {inb, ADDR_W'(pr[COORD_W-1:0]) * ADDR_W'(IMG_W) + ADDR_W'(pc[COORD_W-1:0])};
  endfunction

  assign start_ok = i_start && (state == IDLE || state == DONE)
                 && ({1'b0, i_row} < ROW_LIM) && ({1'b0, i_col} < COL_LIM);
  assign first_rd = slot_rd(i_row, i_col, 4'd0);
  assign next_rd  = slot_rd(c_row, c_col, slot + 4'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      slot       <= '0;
      c_row      <= '0;
      c_col      <= '0;
      pend       <= 1'b0;
      pend_rd    <= 1'b0;
      pend_slot  <= '0;
      win        <= '0;
      o_mem_ren  <= 1'b0;
      o_mem_addr <= '0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      pend <= 1'b0;
      // Read data lands one cycle after its enable; padded taps write zero.
      if (pend) win[pend_slot] <= pend_rd ? i_mem_rdata : '0;
      case (state)
        IDLE, DONE: begin
          o_valid <= 1'b0;
          state   <= IDLE;
          if (start_ok) begin
            state     <= FETCH;
            o_busy    <= 1'b1;
            c_row     <= i_row;
            c_col     <= i_col;
            slot      <= '0;
            o_mem_ren <= first_rd[ADDR_W];
            if (first_rd[ADDR_W]) o_mem_addr <= first_rd[ADDR_W-1:0];
          end
        end
        FETCH: begin
          pend      <= 1'b1;
          pend_rd   <= o_mem_ren;
          pend_slot <= slot;
          if (slot == 4'd8) begin
            state     <= DRAIN;
            o_mem_ren <= 1'b0;
          end else begin
            slot      <= slot + 4'd1;
            o_mem_ren <= next_rd[ADDR_W];
            if (next_rd[ADDR_W]) o_mem_addr <= next_rd[ADDR_W-1:0];
          end
        end
        DRAIN: begin
          state   <= DONE;
          o_busy  <= 1'b0;
          o_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_data0 = win[0];
  assign o_data1 = win[1];
  assign o_data2 = win[2];
  assign o_data3 = win[3];
  assign o_data4 = win[4];
  assign o_data5 = win[5];
  assign o_data6 = win[6];
  assign o_data7 = win[7];
  assign o_data8 = win[8];

endmodule

// File: tb/tb_median_window_fetch.sv
// Bench for median_window_fetch: SRAM model mem[a]=a+1 and a tap-by-tap window model.
module tb_median_window_fetch;
  localparam int CW = 4, AW = 6, DW = 8, W = 8, H = 8;

  logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [CW-1:0] row = '0, col = '0;
  logic          ren, busy, valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
  logic [DW-1:0] dv [9];

  int vectors = 0, errors = 0;
  int exp_d [9];
  int exp_a [$];
  int rd_q  [$];

  median_window_fetch #(.IMG_W(W), .IMG_H(H), .COORD_W(CW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_row(row), .i_col(col),
    .o_mem_ren(ren), .o_mem_addr(addr), .i_mem_rdata(rdata),
    .o_busy(busy), .o_valid(valid),
    .o_data0(d0), .o_data1(d1), .o_data2(d2), .o_data3(d3), .o_data4(d4),
    .o_data5(d5), .o_data6(d6), .o_data7(d7), .o_data8(d8));

  always #5 clk = ~clk;

  assign dv[0] = d0; assign dv[1] = d1; assign dv[2] = d2;
  assign dv[3] = d3; assign dv[4] = d4; assign dv[5] = d5;
  assign dv[6] = d6; assign dv[7] = d7; assign dv[8] = d8;

  // Synchronous-read SRAM plus a log of every read issued
  always @(posedge clk) begin
    if (ren) begin
      rdata <= DW'(int'(addr) + 1);
      rd_q.push_back(int'(addr));
      vectors++;
      if (int'(addr) >= W * H) begin
        errors++;
        $display("FAIL read_range: addr %0d, limit %0d", addr, W * H - 1);
      end
    end
  end

  // Window as the neighbourhood of (r,c) in row-major order, off-image taps = 0
  function automatic void model(int r, int c);
    exp_a.delete();
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int rr = r + dr, cc = c + dc, idx = (dr + 1) * 3 + (dc + 1);
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
          exp_a.push_back(rr * W + cc);
          exp_d[idx] = (rr * W + cc + 1) % 256;
        end else exp_d[idx] = 0;
      end
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ren, busy, valid} !== 3'b000 || addr !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: ren/busy/valid/addr %b%b%b/%0d, want 000/0", ren, busy, valid, addr);
    end
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (dv[i] !== '0) begin
        errors++;
        $display("FAIL reset_data%0d: got %0d want 0", i, dv[i]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_window(string tag, int r, int c);
    model(r, c);
    @(negedge clk);
    rd_q.delete();
    row = CW'(r); col = CW'(c); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      vectors++;
      if (valid !== (i == 11) || busy !== (i != 11)) begin
        errors++;
        $display("FAIL %s timing cyc%0d: valid/busy %b/%b want %b/%b", tag, i, valid, busy, i == 11, i != 11);
      end
    end
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (int'(dv[i]) != exp_d[i]) begin
        errors++;
        $display("FAIL %s data%0d: got %0d want %0d", tag, i, dv[i], exp_d[i]);
      end
    end
    vectors++;
    if (rd_q != exp_a) begin
      errors++;
      $display("FAIL %s reads: got %p want %p", tag, rd_q, exp_a);
    end
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    row = 4'd3; col = 4'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ren, busy, valid} !== 3'b000 || addr !== '0 || d0 !== '0 || d4 !== '0) begin
      errors++;
      $display("FAIL midreset_clear: ren/busy/valid %b%b%b addr %0d d0 %0d d4 %0d, want all 0",
               ren, busy, valid, addr, d0, d4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd_q.delete();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      vectors++;
      if ({ren, busy, valid} !== 3'b000) begin
        errors++;
        $display("FAIL midreset_idle cyc%0d: ren/busy/valid %b%b%b want 000", i, ren, busy, valid);
      end
    end
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (dv[i] !== '0) begin
        errors++;
        $display("FAIL midreset_data%0d: got %0d want 0", i, dv[i]);
      end
    end
    vectors++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_reads: got %0d reads want 0", rd_q.size());
    end
  endtask

  task automatic test_illegal(int r, int c);
    @(negedge clk);
    rd_q.delete();
    row = CW'(r); col = CW'(c); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vectors++;
      if ({ren, busy, valid} !== 3'b000) begin
        errors++;
        $display("FAIL illegal(%0d,%0d) cyc%0d: ren/busy/valid %b%b%b want 000", r, c, i, ren, busy, valid);
      end
    end
    vectors++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL illegal(%0d,%0d) reads: got %0d want 0", r, c, rd_q.size());
    end
  endtask

  task automatic test_back_to_back();
    model(3, 4);
    @(negedge clk);
    rd_q.delete();
    row = 4'd3; col = 4'd4; start = 1'b1;
    @(posedge clk); #1 row = 4'd1; col = 4'd1;  // start stays high through the busy window
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      vectors++;
      if (valid !== (i == 11) || busy !== (i != 11)) begin
        errors++;
        $display("FAIL b2b_first cyc%0d: valid/busy %b/%b want %b/%b", i, valid, busy, i == 11, i != 11);
      end
    end
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (int'(dv[i]) != exp_d[i]) begin
        errors++;
        $display("FAIL b2b_first data%0d: got %0d want %0d", i, dv[i], exp_d[i]);
      end
    end
    vectors++;
    if (rd_q != exp_a) begin
      errors++;
      $display("FAIL b2b_first reads: got %p want %p", rd_q, exp_a);
    end
    model(1, 1);
    rd_q.delete();
    @(posedge clk); #1 start = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      vectors++;
      if (valid !== (i == 11) || busy !== (i != 11)) begin
        errors++;
        $display("FAIL b2b_second cyc%0d: valid/busy %b/%b want %b/%b", i, valid, busy, i == 11, i != 11);
      end
    end
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (int'(dv[i]) != exp_d[i]) begin
        errors++;
        $display("FAIL b2b_second data%0d: got %0d want %0d", i, dv[i], exp_d[i]);
      end
    end
    vectors++;
    if (rd_q != exp_a) begin
      errors++;
      $display("FAIL b2b_second reads: got %p want %p", rd_q, exp_a);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_fetch();
    test_window("interior", 3, 4);
    test_window("corner00", 0, 0);
    test_window("corner77", 7, 7);
    test_back_to_back();
    test_illegal(8, 0);
    test_illegal(0, 8);
    for (int n = 0; n < 10; n++) begin
      int r = int'($urandom_range(0, H - 1));
      int c = int'($urandom_range(0, W - 1));
      test_window($sformatf("rand(%0d,%0d)", r, c), r, c);
    end
    for (int n = 0; n < 3; n++)
      test_illegal(int'($urandom_range(H, 15)), int'($urandom_range(0, 15)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
